// File: rtl/multicycle_control_if.sv
// Control-unit bundle between the multi-cycle MIPS main control FSM and the datapath.
// master: the control FSM. It takes opcode/mem_ready and drives the selects, enables and status.
// slave : the datapath/memory side. It drives opcode/mem_ready and consumes the controls.
interface multicycle_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       ir_write;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal_op;
   logic       bus_error;
   logic [3:0] state_o;

   modport master (
      input  opcode, mem_ready,
      output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
             bus_error, state_o
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
             bus_error, state_o
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM. It sequences fetch/decode/execute/memory/writeback,
// shares the single ALU across steps, and aborts a memory wait after MEM_TIMEOUT cycles.
// Ports: clk, reset (async, active-high), bus (multicycle_control_if.master):
//   opcode/mem_ready in; datapath selects, write enables, alu_op, illegal_op,
//   bus_error and state_o out.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master bus
);

   localparam int unsigned CNT_W = 8;
   // The counter starts at 0 in the first wait cycle, so the last allowed wait cycle is at MEM_TIMEOUT-1.
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      MEM_ADDR = 4'd4,
      MEM_RD   = 4'd5,
      MEM_WR   = 4'd6,
      WB_R     = 4'd7,
      WB_I     = 4'd8,
      WB_MEM   = 4'd9,
      JUMP     = 4'd10
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [5:0]       opcode_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             in_wait;
   logic             timeout;
   logic             op_illegal;
   logic             bus_error_q;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   // Latched opcode, memory wait counter and the registered bus_error pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opcode_q    <= '0;
         wait_cnt    <= '0;
         bus_error_q <= 1'b0;
      end else begin
         if (state == DECODE) opcode_q <= bus.opcode;
         // Any state change or abort restarts the count. This covers every entry into a wait state.
         if (state_next != state || timeout) wait_cnt <= '0;
         else if (in_wait && !bus.mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
         bus_error_q <= timeout;
      end
   end

   // Next-state logic and opcode dispatch
   always_comb begin
      state_next = state;
      in_wait    = 1'b0;
      timeout    = 1'b0;
      op_illegal = 1'b0;
      case (state)
         FETCH: begin
            in_wait = 1'b1;
            if (bus.mem_ready) state_next = DECODE;
            else if (wait_cnt == WAIT_LIMIT) timeout = 1'b1;
         end
         DECODE: begin
            case (bus.opcode)
               OP_RTYPE:                        state_next = EXEC_R;
               OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_next = EXEC_I;
               OP_LW, OP_SW:                    state_next = MEM_ADDR;
               OP_J:                            state_next = JUMP;
               default: begin
                  op_illegal = 1'b1;
                  state_next = FETCH;
               end
            endcase
         end
         EXEC_R:   state_next = WB_R;
         EXEC_I:   state_next = WB_I;
         MEM_ADDR: state_next = (opcode_q == OP_SW) ? MEM_WR : MEM_RD;
         MEM_RD: begin
            in_wait = 1'b1;
            if (bus.mem_ready) state_next = WB_MEM;
            else if (wait_cnt == WAIT_LIMIT) begin
               timeout    = 1'b1;
               state_next = FETCH;
            end
         end
         MEM_WR: begin
            in_wait = 1'b1;
            if (bus.mem_ready) state_next = FETCH;
            else if (wait_cnt == WAIT_LIMIT) begin
               timeout    = 1'b1;
               state_next = FETCH;
            end
         end
         WB_R, WB_I, WB_MEM, JUMP: state_next = FETCH;
         default:                  state_next = FETCH;
      endcase
   end

   // Output decode from the registered state. Reset forces FETCH asynchronously,
   // so write enables drop at once without waiting for a clock edge.
   always_comb begin
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.alu_op     = 3'b000;
      bus.pc_source  = 2'b00;
      bus.illegal_op = 1'b0;
      bus.bus_error  = bus_error_q;
      bus.state_o    = state;
      case (state)
         FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.alu_op    = 3'b110;
            // PC+4 and the IR load commit only on a completed fetch, and never while reset is held.
            bus.pc_write  = bus.mem_ready & ~reset;
            bus.ir_write  = bus.mem_ready & ~reset;
         end
         DECODE: bus.illegal_op = op_illegal;
         EXEC_R: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b00;
            bus.alu_op    = 3'b111;
         end
         EXEC_I: begin
            bus.alu_src_a = 1'b1;
            case (opcode_q)
               OP_ORI: begin
                  bus.alu_op    = 3'b101;
                  bus.alu_src_b = 2'b11;
               end
               OP_ANDI: begin
                  bus.alu_op    = 3'b011;
                  bus.alu_src_b = 2'b11;
               end
               OP_LUI: begin
                  bus.alu_op    = 3'b001;
                  bus.alu_src_b = 2'b10;
               end
               default: begin
                  bus.alu_op    = 3'b110;
                  bus.alu_src_b = 2'b10;
               end
            endcase
         end
         MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            bus.alu_op    = 3'b010;
         end
         MEM_RD: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         MEM_WR: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
         end
         WB_R: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
         end
         WB_I:   bus.reg_write = 1'b1;
         WB_MEM: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A reference model builds the expected
// per-cycle state trace of each instruction from its class and its memory wait counts.
// A per-state table gives the expected control outputs.
module tb_multicycle_control;

   localparam int unsigned MEM_TIMEOUT = 15;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   multicycle_control_if bus ();

   multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int st;
      bit rdy;
      bit berr;
   } cyc_t;

   cyc_t trace[$];
   bit   berr_pend;

   // 0 illegal, 1 R-type, 2 I-type, 3 LW, 4 SW, 5 J
   function automatic int op_class(logic [5:0] op);
      case (op)
         OP_RTYPE:                        return 1;
         OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: return 2;
         OP_LW:                           return 3;
         OP_SW:                           return 4;
         OP_J:                            return 5;
         default:                         return 0;
      endcase
   endfunction

   function automatic void push(int st, bit rdy);
      cyc_t c;
      c.st = st;
      c.rdy = rdy;
      c.berr = berr_pend;
      trace.push_back(c);
      berr_pend = 1'b0;
   endfunction

   // Memory wait of 'waits' not-ready cycles. Returns 1 if it is aborted by the timeout.
   function automatic bit add_wait(int st, int waits);
      for (int n = 0; n < int'(MEM_TIMEOUT); n++) begin
         if (n == waits) begin
            push(st, 1'b1);
            return 1'b0;
         end
         push(st, 1'b0);
      end
      berr_pend = 1'b1;
      return 1'b1;
   endfunction

   function automatic void build(logic [5:0] op, int fw, int mw);
      trace.delete();
      while (add_wait(0, fw)) fw = fw - int'(MEM_TIMEOUT);
      push(1, 1'($urandom));
      case (op_class(op))
         1: begin push(2, 1'($urandom)); push(7, 1'($urandom)); end
         2: begin push(3, 1'($urandom)); push(8, 1'($urandom)); end
         3: begin
            push(4, 1'($urandom));
            if (!add_wait(5, mw)) push(9, 1'($urandom));
         end
         4: begin
            push(4, 1'($urandom));
            void'(add_wait(6, mw));
         end
         5: push(10, 1'($urandom));
         default: ;
      endcase
   endfunction

   // Expected {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
   //           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, bus_error}
   function automatic logic [17:0] exp_out(int st, logic [5:0] op, bit rdy, bit berr);
      logic pcw, irw, iod, mr, mw, rw, rd, m2r, sa, ill;
      logic [1:0] sb, ps;
      logic [2:0] ao;
      {pcw, irw, iod, mr, mw, rw, rd, m2r, sa, ill} = '0;
      sb = 2'b00; ps = 2'b00; ao = 3'b000;
      case (st)
         0:  begin mr = 1; sb = 2'b01; ao = 3'b110; pcw = rdy; irw = rdy; end
         1:  ill = (op_class(op) == 0);
         2:  begin sa = 1; sb = 2'b00; ao = 3'b111; end
         3: begin
            sa = 1;
            case (op)
               OP_ORI:  begin ao = 3'b101; sb = 2'b11; end
               OP_ANDI: begin ao = 3'b011; sb = 2'b11; end
               OP_LUI:  begin ao = 3'b001; sb = 2'b10; end
               default: begin ao = 3'b110; sb = 2'b10; end
            endcase
         end
         4:  begin sa = 1; sb = 2'b10; ao = 3'b010; end
         5:  begin mr = 1; iod = 1; end
         6:  begin mw = 1; iod = 1; end
         7:  begin rw = 1; rd = 1; end
         8:  rw = 1;
         9:  begin rw = 1; m2r = 1; end
         10: begin pcw = 1; ps = 2'b10; end
         default: ;
      endcase
      return {pcw, irw, iod, mr, mw, rw, rd, m2r, sa, sb, ao, ps, ill, berr};
   endfunction

   function automatic logic [17:0] got_out();
      return {bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write,
              bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
              bus.alu_op, bus.pc_source, bus.illegal_op, bus.bus_error};
   endfunction

   // Runs one instruction from FETCH back to FETCH, checking every cycle. Entered at posedge+1.
   task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw);
      logic [17:0] exp, got;
      build(op, fw, mw);
      for (int i = 0; i < trace.size(); i++) begin
         bus.mem_ready = trace[i].rdy;
         bus.opcode    = (trace[i].st == 1) ? op : 6'($urandom);
         @(negedge clk);
         checks++;
         if (bus.state_o !== 4'(trace[i].st)) begin
            errors++;
            $display("FAIL %s op=%b cycle %0d state_o: got %0d expected %0d",
                     name, op, i, bus.state_o, trace[i].st);
         end
         exp = exp_out(trace[i].st, op, trace[i].rdy, trace[i].berr);
         got = got_out();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s op=%b cycle %0d outputs (state %0d): got %b expected %b",
                     name, op, i, trace[i].st, got, exp);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.mem_ready = 1'b1;
      bus.opcode = OP_J;
      berr_pend = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.state_o !== 4'd0 || bus.mem_read !== 1'b1 || bus.pc_write !== 1'b0 ||
             bus.ir_write !== 1'b0 || bus.alu_op !== 3'b110 || bus.alu_src_b !== 2'b01) begin
            errors++;
            $display("FAIL reset_hold: state=%0d mem_read=%b pc_write=%b ir_write=%b alu_op=%b src_b=%b expected 0 1 0 0 110 01",
                     bus.state_o, bus.mem_read, bus.pc_write, bus.ir_write, bus.alu_op, bus.alu_src_b);
         end
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (got_out() !== exp_out(0, OP_J, 1'b1, 1'b0)) begin
         errors++;
         $display("FAIL reset_release: got %b expected %b", got_out(), exp_out(0, OP_J, 1'b1, 1'b0));
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (bus.state_o !== 4'd1) begin
         errors++;
         $display("FAIL reset_decode: state_o got %0d expected 1", bus.state_o);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (bus.state_o !== 4'd10 || bus.pc_write !== 1'b1 || bus.pc_source !== 2'b10) begin
         errors++;
         $display("FAIL reset_jump: state=%0d pc_write=%b pc_source=%b expected 10 1 10",
                  bus.state_o, bus.pc_write, bus.pc_source);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_rtype();
      run_instr("rtype", OP_RTYPE, 0, 0);
      run_instr("rtype_fetch_wait", OP_RTYPE, 2, 0);
   endtask

   task automatic test_itype();
      run_instr("ori", OP_ORI, 0, 0);
      run_instr("addi", OP_ADDI, 0, 0);
      run_instr("andi", OP_ANDI, 1, 0);
      run_instr("lui", OP_LUI, 0, 0);
   endtask

   task automatic test_lw();
      run_instr("lw_wait3", OP_LW, 0, 3);
      run_instr("lw_fast", OP_LW, 0, 0);
   endtask

   task automatic test_sw_timeout();
      run_instr("sw_timeout", OP_SW, 0, 20);
      run_instr("after_timeout", OP_RTYPE, 0, 0);
   endtask

   task automatic test_boundary();
      run_instr("sw_complete_at_limit", OP_SW, 0, int'(MEM_TIMEOUT) - 1);
      run_instr("lw_timeout", OP_LW, 0, int'(MEM_TIMEOUT));
      run_instr("fetch_timeout", OP_ADDI, int'(MEM_TIMEOUT) + 1, 0);
   endtask

   task automatic test_illegal();
      run_instr("illegal", 6'b111111, 0, 0);
      run_instr("jump", OP_J, 0, 0);
   endtask

   task automatic test_mid_reset();
      bus.opcode = OP_SW;
      bus.mem_ready = 1'b1;
      @(posedge clk);
      #1 bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (bus.state_o !== 4'd6 || bus.mem_write !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_setup: state=%0d mem_write=%b expected 6 1", bus.state_o, bus.mem_write);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.mem_write !== 1'b0 || bus.state_o !== 4'd0 || bus.bus_error !== 1'b0 ||
          bus.illegal_op !== 1'b0 || bus.reg_write !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_async: mem_write=%b state=%0d bus_error=%b illegal=%b reg_write=%b expected 0 0 0 0 0",
                  bus.mem_write, bus.state_o, bus.bus_error, bus.illegal_op, bus.reg_write);
      end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_random();
      logic [5:0] ops[8];
      logic [5:0] op;
      int fw, mw;
      ops = '{OP_RTYPE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 7)];
         else op = 6'($urandom);
         fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 2));
         mw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 4));
         run_instr("random", op, fw, mw);
      end
      run_instr("final", OP_J, 0, 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.opcode = '0;
      bus.mem_ready = 1'b0;
      test_reset();
      test_rtype();
      test_itype();
      test_lw();
      test_sw_timeout();
      test_illegal();
      test_mid_reset();
      test_boundary();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time bound so the run always ends, even if the DUT stalls the sequence.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
